pipe_ctrl_unit: RTL
===================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter ALUOP_W, default 3, ALU-operation code width (minimum 3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 opcode  input  6  instruction opcode in ID.
REQ-007 id_rs, id_rt  input  REG_ADDR_W each  source register fields in ID.
REQ-008 flush  input  1  branch/jump resolved taken; kill the younger instruction.
REQ-009 stall  output  1  load-use hazard; hold PC and IF/ID.
REQ-010 ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne, ex_jump  output  1 each  EX-stage controls.
REQ-011 ex_alu_op  output  ALUOP_W  EX-stage ALU operation class.
REQ-012 mem_read, mem_write  output  1 each  MEM-stage controls.
REQ-013 wb_reg_write, wb_mem_to_reg, wb_link  output  1 each  WB-stage controls.

Function
REQ-014 Decode SHALL be combinational in ID; bundle fields: reg_dst, alu_src, alu_op, branch, branch_ne, jump, link, mem_read, mem_write, mem_to_reg, reg_write, uses_rt.
REQ-015 Decode table SHALL be: R 000000 {reg_dst, reg_write, alu_op=010, uses_rt}; lw 100011 {alu_src, mem_read, mem_to_reg, reg_write, alu_op=000}; sw 101011 {alu_src, mem_write, alu_op=000, uses_rt}; beq 000100 {branch, alu_op=001, uses_rt}; bne 000101 {branch, branch_ne, alu_op=001, uses_rt}; addi 001000 {alu_src, reg_write, 000}; andi 001100 {alu_src, reg_write, 011}; ori 001101 {alu_src, reg_write, 100}; slti 001010 {alu_src, reg_write, 101}; j 000010 {jump}.
REQ-016 Unlisted opcodes, or id_valid=0, SHALL decode to all-zero bundle (bubble).
REQ-017 Bundle SHALL pass ID->EX->MEM->WB through three registers, one cycle per stage; EX outputs valid 1 cycle after ID decode, MEM after 2, WB after 3.
REQ-018 ID/EX register SHALL also capture id_rt as ex_rt for hazard detection.
REQ-019 stall SHALL be combinational: id_valid & ex mem_read & (ex_rt != 0) & (ex_rt == id_rs | (uses_rt & ex_rt == id_rt)).
REQ-020 When stall=1, ID/EX SHALL load a bubble; EX/MEM and MEM/WB advance normally.
REQ-021 When flush=1, ID/EX SHALL load a bubble; stall SHALL be forced to 0 (flush wins over stall).
REQ-022 Bubble SHALL have all fields zero, including ex_rt.
REQ-023 Back-to-back lw then dependent instruction SHALL stall exactly one cycle; second cycle's check sees bubble in EX and releases.
REQ-024 Register index 0 SHALL never cause a stall.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all three pipeline registers; every ex_*, mem_*, wb_* output reads 0 and stall reads 0 while in reset.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight bundles; first decode after release enters EX on the next edge.

Configuration
REQ-027 Macro PIPE_CTRL_JAL_EN SHALL, when defined, decode jal 000011 as {jump, link, reg_write}, with wb_link=1 three cycles later.
REQ-028 Without PIPE_CTRL_JAL_EN, 000011 SHALL decode as bubble, and wb_link SHALL be tied to 0.

Verification
REQ-029 Reset: rst_n=0 mid-stream with lw in MEM -> all outputs 0 immediately, no clock edge required.
REQ-030 Latency: addi at cycle 0 -> ex_alu_src=1, ex_alu_op=000 at cycle 1; wb_reg_write=1 at cycle 3, wb_mem_to_reg=0.
REQ-031 Load-use: lw rt=5, then add rs=5 -> stall=1 for one cycle, EX shows bubble, add reaches EX one cycle late; mem_read=1 during the bubble cycle.
REQ-032 No false stall: lw rt=0 then add rs=0 -> stall stays 0; lw rt=7 then addi rt=7 rs=3 -> stall stays 0 (uses_rt=0).
REQ-033 Flush priority: flush=1 together with load-use condition -> stall=0, ex_* all 0 next cycle.
REQ-034 Config: opcode 000011 -> with PIPE_CTRL_JAL_EN ex_jump=1 and wb_link=1 three cycles later; without it, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX/MEM/WB control registers and load-use stall.
// Optional macro PIPE_CTRL_JAL_EN adds jal decode and drives wb_link.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [5:0]            opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_branch_ne,
  output logic                  ex_jump,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_link
);

  logic               dec_valid_s;
  logic               dec_reg_dst_s;
  logic               dec_alu_src_s;
  logic [ALUOP_W-1:0] dec_alu_op_s;
  logic               dec_branch_s;
  logic               dec_branch_ne_s;
  logic               dec_jump_s;
  logic               dec_mem_read_s;
  logic               dec_mem_write_s;
  logic               dec_mem_to_reg_s;
  logic               dec_reg_write_s;
  logic               dec_uses_rt_s;
  logic               id_bubble_s;

  logic                  ex_mem_read_r;
  logic                  ex_mem_write_r;
  logic                  ex_mem_to_reg_r;
  logic                  ex_reg_write_r;
  logic [REG_ADDR_W-1:0] ex_rt_r;
  logic                  mem_mem_to_reg_r;
  logic                  mem_reg_write_r;

`ifdef PIPE_CTRL_JAL_EN
  logic dec_link_s;
  logic ex_link_r;
  logic mem_link_r;
`endif

  // Opcode decode; invalid slots and unknown opcodes fall through to the all-zero bubble.
  always_comb begin
    dec_valid_s      = 1'b0;
    dec_reg_dst_s    = 1'b0;
    dec_alu_src_s    = 1'b0;
    dec_alu_op_s     = {ALUOP_W{1'b0}};
    dec_branch_s     = 1'b0;
    dec_branch_ne_s  = 1'b0;
    dec_jump_s       = 1'b0;
    dec_mem_read_s   = 1'b0;
    dec_mem_write_s  = 1'b0;
    dec_mem_to_reg_s = 1'b0;
    dec_reg_write_s  = 1'b0;
    dec_uses_rt_s    = 1'b0;
`ifdef PIPE_CTRL_JAL_EN
    dec_link_s       = 1'b0;
`endif
    case ({id_valid, opcode})
      7'b1_000000: begin
        dec_valid_s = 1'b1; dec_reg_dst_s = 1'b1; dec_reg_write_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b010); dec_uses_rt_s = 1'b1;
      end
      7'b1_100011: begin
        dec_valid_s = 1'b1; dec_alu_src_s = 1'b1; dec_mem_read_s = 1'b1;
        dec_mem_to_reg_s = 1'b1; dec_reg_write_s = 1'b1; dec_alu_op_s = ALUOP_W'(3'b000);
      end
      7'b1_101011: begin
        dec_valid_s = 1'b1; dec_alu_src_s = 1'b1; dec_mem_write_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b000); dec_uses_rt_s = 1'b1;
      end
      7'b1_000100: begin
        dec_valid_s = 1'b1; dec_branch_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b001); dec_uses_rt_s = 1'b1;
      end
      7'b1_000101: begin
        dec_valid_s = 1'b1; dec_branch_s = 1'b1; dec_branch_ne_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b001); dec_uses_rt_s = 1'b1;
      end
      7'b1_001000: begin
        dec_valid_s = 1'b1; dec_alu_src_s = 1'b1; dec_reg_write_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b000);
      end
      7'b1_001100: begin
        dec_valid_s = 1'b1; dec_alu_src_s = 1'b1; dec_reg_write_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b011);
      end
      7'b1_001101: begin
        dec_valid_s = 1'b1; dec_alu_src_s = 1'b1; dec_reg_write_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b100);
      end
      7'b1_001010: begin
        dec_valid_s = 1'b1; dec_alu_src_s = 1'b1; dec_reg_write_s = 1'b1;
        dec_alu_op_s = ALUOP_W'(3'b101);
      end
      7'b1_000010: begin
        dec_valid_s = 1'b1; dec_jump_s = 1'b1;
      end
`ifdef PIPE_CTRL_JAL_EN
      7'b1_000011: begin
        dec_valid_s = 1'b1; dec_jump_s = 1'b1; dec_link_s = 1'b1; dec_reg_write_s = 1'b1;
      end
`endif
      default: begin
        dec_valid_s = 1'b0;
      end
    endcase
  end

  // Load-use hazard against the load sitting in EX; flush kills the consumer so never stalls.
  assign stall = ~flush & id_valid & ex_mem_read_r & (ex_rt_r != {REG_ADDR_W{1'b0}}) &
                 ((ex_rt_r == id_rs) | (dec_uses_rt_s & (ex_rt_r == id_rt)));

  assign id_bubble_s = stall | flush | ~dec_valid_s;

  // ID/EX register; a bubble zeroes every field including the tracked rt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_dst      <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_alu_op       <= {ALUOP_W{1'b0}};
      ex_branch       <= 1'b0;
      ex_branch_ne    <= 1'b0;
      ex_jump         <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      ex_mem_write_r  <= 1'b0;
      ex_mem_to_reg_r <= 1'b0;
      ex_reg_write_r  <= 1'b0;
      ex_rt_r         <= {REG_ADDR_W{1'b0}};
    end else if (id_bubble_s) begin
      ex_reg_dst      <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_alu_op       <= {ALUOP_W{1'b0}};
      ex_branch       <= 1'b0;
      ex_branch_ne    <= 1'b0;
      ex_jump         <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      ex_mem_write_r  <= 1'b0;
      ex_mem_to_reg_r <= 1'b0;
      ex_reg_write_r  <= 1'b0;
      ex_rt_r         <= {REG_ADDR_W{1'b0}};
    end else begin
      ex_reg_dst      <= dec_reg_dst_s;
      ex_alu_src      <= dec_alu_src_s;
      ex_alu_op       <= dec_alu_op_s;
      ex_branch       <= dec_branch_s;
      ex_branch_ne    <= dec_branch_ne_s;
      ex_jump         <= dec_jump_s;
      ex_mem_read_r   <= dec_mem_read_s;
      ex_mem_write_r  <= dec_mem_write_s;
      ex_mem_to_reg_r <= dec_mem_to_reg_s;
      ex_reg_write_r  <= dec_reg_write_s;
      ex_rt_r         <= id_rt;
    end
  end

  // EX/MEM and MEM/WB registers always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_mem_to_reg_r <= 1'b0;
      mem_reg_write_r  <= 1'b0;
      wb_reg_write     <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
    end else begin
      mem_read         <= ex_mem_read_r;
      mem_write        <= ex_mem_write_r;
      mem_mem_to_reg_r <= ex_mem_to_reg_r;
      mem_reg_write_r  <= ex_reg_write_r;
      wb_reg_write     <= mem_reg_write_r;
      wb_mem_to_reg    <= mem_mem_to_reg_r;
    end
  end

`ifdef PIPE_CTRL_JAL_EN
  // Link flag follows the jal through all three stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_link_r  <= 1'b0;
      mem_link_r <= 1'b0;
      wb_link    <= 1'b0;
    end else begin
      ex_link_r  <= id_bubble_s ? 1'b0 : dec_link_s;
      mem_link_r <= ex_link_r;
      wb_link    <= mem_link_r;
    end
  end
`else
  assign wb_link = 1'b0;
`endif

endmodule
